column_buffer: RTL and testbench

- Downstream sink of the DDA output FIFO.
- Collects one frame of per-ray column records, each indexed by hcount_ray, into a ping-pong column memory.
- Swaps banks only at frame boundaries.
- Serves the pixel renderer: for each (hcount, vcount) request it returns wall/no-wall, wall attributes and the row offset inside the wall slice, with fixed latency.

---
 rtl/column_buffer.sv | 167 ++++++++++++++++
 tb/tb_column_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/column_buffer.sv
// column_buffer: ping-pong store of per-ray wall records fed by the DDA stream,
// with a fixed 2-cycle lookup pipeline serving the pixel renderer.
module column_buffer #(
   parameter int SCREEN_WIDTH  = 320,
   parameter int SCREEN_HEIGHT = 240
) (
   input  logic        pixel_clk_in,
   input  logic        rst_n_in,
   input  logic        dda_tvalid_in,
   input  logic [37:0] dda_tdata_in,
   input  logic        dda_tlast_in,
   output logic        dda_tready_out,
   input  logic        new_frame_in,
   input  logic        pix_valid_in,
   input  logic [8:0]  hcount_in,
   input  logic [7:0]  vcount_in,
   output logic        pix_valid_out,
   output logic [8:0]  hcount_out,
   output logic [7:0]  vcount_out,
   output logic        wall_out,
   output logic        wallType_out,
   output logic [3:0]  mapData_out,
   output logic [15:0] wallX_out,
   output logic [7:0]  wallRow_out,
   output logic        frame_ready_out,
   output logic        err_range_out,
   output logic [7:0]  stale_frames_out
);
   localparam int DEPTH  = 2 * SCREEN_WIDTH;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int REC_W  = 29;

   // Both banks share one array; bank 1 starts at SCREEN_WIDTH.
   function automatic logic [ADDR_W-1:0] bank_addr(input logic bank, input logic [8:0] col);
      logic [ADDR_W-1:0] col_a;
      col_a = (int'(col) < SCREEN_WIDTH) ? ADDR_W'(col) : '0;
      return bank ? (ADDR_W'(SCREEN_WIDTH) + col_a) : col_a;
   endfunction

   function automatic logic [7:0] clamp_height(input logic [7:0] lh);
      return (int'(lh) > SCREEN_HEIGHT) ? 8'(SCREEN_HEIGHT) : lh;
   endfunction

   function automatic logic [7:0] draw_start(input logic [7:0] h);
      return 8'((SCREEN_HEIGHT - int'(h)) >> 1);
   endfunction

   logic [REC_W-1:0] r_mem [DEPTH];

   logic             r_wr_bank;
   logic             r_rd_bank;
   logic             r_full;
   logic             r_tready;
   logic             r_display_valid;
   logic             r_err;
   logic [7:0]       r_stale;

   logic             w_hs;
   logic             w_in_range;
   logic             w_swap;
   logic             w_full_nxt;

   assign w_hs       = dda_tvalid_in && r_tready;
   assign w_in_range = int'(dda_tdata_in[37:29]) < SCREEN_WIDTH;
   assign w_swap     = new_frame_in && r_full;

   // A swap always wins: a handshake cannot coincide with it because tready tracks !full.
   always_comb begin
      w_full_nxt = r_full;
      if (w_swap)
         w_full_nxt = 1'b0;
      else if (w_hs && dda_tlast_in)
         w_full_nxt = 1'b1;
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_wr_bank       <= 1'b0;
         r_rd_bank       <= 1'b1;
         r_full          <= 1'b0;
         r_tready        <= 1'b0;
         r_display_valid <= 1'b0;
         r_err           <= 1'b0;
         r_stale         <= 8'd0;
      end else begin
         r_full   <= w_full_nxt;
         r_tready <= !w_full_nxt;
         if (w_swap) begin
            r_wr_bank       <= r_rd_bank;
            r_rd_bank       <= r_wr_bank;
            r_display_valid <= 1'b1;
         end else if (new_frame_in && (r_stale != 8'hFF)) begin
            r_stale <= r_stale + 8'd1;
         end
         if (w_hs && !w_in_range)
            r_err <= 1'b1;
      end
   end

   assign dda_tready_out   = r_tready;
   assign frame_ready_out  = r_full;
   assign err_range_out    = r_err;
   assign stale_frames_out = r_stale;

   // Stage 1: column memory write and registered read of the display bank
   logic [REC_W-1:0] r_rec_p1;
   logic             r_vld_p1;
   logic             r_dv_p1;
   logic [8:0]       r_hc_p1;
   logic [7:0]       r_vc_p1;

   always_ff @(posedge pixel_clk_in) begin
      if (w_hs && w_in_range)
         r_mem[bank_addr(r_wr_bank, dda_tdata_in[37:29])] <= dda_tdata_in[REC_W-1:0];
      r_rec_p1 <= r_mem[bank_addr(r_rd_bank, hcount_in)];
   end

   // display_valid travels with the read so a lookup stays tied to the bank it read.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_vld_p1 <= 1'b0;
         r_dv_p1  <= 1'b0;
         r_hc_p1  <= '0;
         r_vc_p1  <= '0;
      end else begin
         r_vld_p1 <= pix_valid_in;
         r_dv_p1  <= r_display_valid;
         r_hc_p1  <= hcount_in;
         r_vc_p1  <= vcount_in;
      end
   end

   // Stage 2: wall slice geometry and output registers
   logic [7:0] w_h;
   logic [7:0] w_start;
   logic [8:0] w_end;
   logic       w_wall;

   assign w_h     = clamp_height(r_rec_p1[28:21]);
   assign w_start = draw_start(w_h);
   assign w_end   = {1'b0, w_start} + {1'b0, w_h};
   assign w_wall  = r_dv_p1 && (w_h != 8'd0) && (r_vc_p1 >= w_start)
                    && ({1'b0, r_vc_p1} < w_end) && (int'(r_hc_p1) < SCREEN_WIDTH);

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pix_valid_out <= 1'b0;
         hcount_out    <= '0;
         vcount_out    <= '0;
         wall_out      <= 1'b0;
         wallType_out  <= 1'b0;
         mapData_out   <= '0;
         wallX_out     <= '0;
         wallRow_out   <= '0;
      end else begin
         pix_valid_out <= r_vld_p1;
         hcount_out    <= r_hc_p1;
         vcount_out    <= r_vc_p1;
         wall_out      <= w_wall;
         wallType_out  <= w_wall ? r_rec_p1[20] : 1'b0;
         mapData_out   <= w_wall ? r_rec_p1[19:16] : 4'd0;
         wallX_out     <= w_wall ? r_rec_p1[15:0] : 16'd0;
         wallRow_out   <= w_wall ? (r_vc_p1 - w_start) : 8'd0;
      end
   end

endmodule

// File: tb/tb_column_buffer.sv
// Randomized scoreboard bench for column_buffer against a frame-level reference model.
module tb_column_buffer;
   localparam int SW = 320;
   localparam int SH = 240;

   logic        clk = 1'b0;
   logic        rst_n_in;
   logic        dda_tvalid_in;
   logic [37:0] dda_tdata_in;
   logic        dda_tlast_in;
   logic        dda_tready_out;
   logic        new_frame_in;
   logic        pix_valid_in;
   logic [8:0]  hcount_in;
   logic [7:0]  vcount_in;
   logic        pix_valid_out;
   logic [8:0]  hcount_out;
   logic [7:0]  vcount_out;
   logic        wall_out;
   logic        wallType_out;
   logic [3:0]  mapData_out;
   logic [15:0] wallX_out;
   logic [7:0]  wallRow_out;
   logic        frame_ready_out;
   logic        err_range_out;
   logic [7:0]  stale_frames_out;

   always #5 clk = ~clk;

   column_buffer #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)) dut (
      .pixel_clk_in     (clk),
      .rst_n_in         (rst_n_in),
      .dda_tvalid_in    (dda_tvalid_in),
      .dda_tdata_in     (dda_tdata_in),
      .dda_tlast_in     (dda_tlast_in),
      .dda_tready_out   (dda_tready_out),
      .new_frame_in     (new_frame_in),
      .pix_valid_in     (pix_valid_in),
      .hcount_in        (hcount_in),
      .vcount_in        (vcount_in),
      .pix_valid_out    (pix_valid_out),
      .hcount_out       (hcount_out),
      .vcount_out       (vcount_out),
      .wall_out         (wall_out),
      .wallType_out     (wallType_out),
      .mapData_out      (mapData_out),
      .wallX_out        (wallX_out),
      .wallRow_out      (wallRow_out),
      .frame_ready_out  (frame_ready_out),
      .err_range_out    (err_range_out),
      .stale_frames_out (stale_frames_out)
   );

   // Reference model: two frame banks, which one is shown, and frame status.
   logic [28:0] m_bank [2][SW];
   int          m_wr, m_rd, m_stale;
   bit          m_full, m_dv, m_err, m_ready;

   logic [46:0] exp_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic logic [37:0] mk_rec(input int hc, input int lh, input int wt, input int map, input int wx);
      return {9'(hc), 8'(lh), 1'(wt), 4'(map), 16'(wx)};
   endfunction

   function automatic logic [46:0] expect_lookup(input int hc, input int vc);
      logic [28:0] rec;
      int          h, ds;
      if (m_dv && hc < SW) begin
         rec = m_bank[m_rd][hc];
         h   = int'(rec[28:21]);
         if (h > SH) h = SH;
         ds  = (SH - h) / 2;
         if (h != 0 && vc >= ds && vc < ds + h)
            return {9'(hc), 8'(vc), 1'b1, rec[20], rec[19:16], rec[15:0], 8'(vc - ds)};
      end
      return {9'(hc), 8'(vc), 1'b0, 1'b0, 4'h0, 16'h0, 8'h0};
   endfunction

   task automatic model_reset();
      m_wr = 0; m_rd = 1; m_full = 0; m_dv = 0; m_err = 0; m_stale = 0; m_ready = 0;
   endtask

   task automatic check_status();
      logic [10:0] got, want;
      got  = {dda_tready_out, frame_ready_out, err_range_out, stale_frames_out};
      want = {m_ready, m_full, m_err, 8'(m_stale)};
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL status t=%0t got tready/frame_ready/err/stale=%b/%b/%b/%0d want %b/%b/%b/%0d",
                  $time, got[10], got[9], got[8], got[7:0], want[10], want[9], want[8], want[7:0]);
      end
   endtask

   task automatic check_all_zero(input string name);
      n_checks++;
      if ({pix_valid_out, hcount_out, vcount_out, wall_out, wallType_out, mapData_out, wallX_out,
           wallRow_out, frame_ready_out, err_range_out, stale_frames_out, dda_tready_out} !== '0) begin
         n_fail++;
         $display("FAIL %s outputs not all zero: pv=%b h=%0d v=%0d wall=%b tready=%b fr=%b err=%b stale=%0d",
                  name, pix_valid_out, hcount_out, vcount_out, wall_out, dda_tready_out,
                  frame_ready_out, err_range_out, stale_frames_out);
      end
   endtask

   // One clock cycle: drive inputs, queue the expected lookup, then advance the model.
   task automatic cyc(input bit tv, input logic [37:0] td, input bit tl, input bit nf,
                      input bit pv, input int hc, input int vc);
      bit hs;
      int t;
      dda_tvalid_in = tv; dda_tdata_in = td; dda_tlast_in = tl; new_frame_in = nf;
      pix_valid_in = pv; hcount_in = 9'(hc); vcount_in = 8'(vc);
      check_status();
      if (pv) exp_q.push_back(expect_lookup(hc, vc));
      hs = tv && m_ready;
      @(posedge clk);
      if (hs) begin
         if (int'(td[37:29]) < SW) m_bank[m_wr][int'(td[37:29])] = td[28:0];
         else                      m_err = 1;
      end
      if (nf && m_full) begin
         t = m_wr; m_wr = m_rd; m_rd = t; m_full = 0; m_dv = 1;
      end else if (nf && m_stale < 255) begin
         m_stale++;
      end
      if (hs && tl) m_full = 1;
      m_ready = !m_full;
      #1;
   endtask

   task automatic idle();
      cyc(0, '0, 0, 0, 0, 0, 0);
   endtask

   task automatic look(input int hc, input int vc);
      cyc(0, '0, 0, 0, 1, hc, vc);
   endtask

   task automatic rand_look();
      cyc(0, '0, 0, 0, 1, $urandom_range(0, 330), $urandom_range(0, 255));
   endtask

   task automatic beat(input logic [37:0] td, input bit tl, input bit nf);
      cyc(1, td, tl, nf, 1'($urandom_range(0, 1)), $urandom_range(0, 330), $urandom_range(0, 255));
   endtask

   function automatic logic [37:0] rand_rec(input int hc);
      return mk_rec(hc, $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 15),
                    $urandom_range(0, 65535));
   endfunction

   logic [46:0] mon_got, mon_exp;
   always @(negedge clk) begin
      if (rst_n_in && pix_valid_out) begin
         mon_got = {hcount_out, vcount_out, wall_out, wallType_out, mapData_out, wallX_out, wallRow_out};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL lookup_unexpected got h=%0d v=%0d with no request outstanding",
                     hcount_out, vcount_out);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               n_fail++;
               $display("FAIL lookup got h=%0d v=%0d wall=%b wt=%b map=%0d wx=%h row=%0d want h=%0d v=%0d wall=%b wt=%b map=%0d wx=%h row=%0d",
                        mon_got[46:38], mon_got[37:30], mon_got[29], mon_got[28], mon_got[27:24], mon_got[23:8], mon_got[7:0],
                        mon_exp[46:38], mon_exp[37:30], mon_exp[29], mon_exp[28], mon_exp[27:24], mon_exp[23:8], mon_exp[7:0]);
            end
         end
      end
   end

   int perm [SW];

   initial begin
      int lh, j, tmp;
      rst_n_in = 1'b0;
      dda_tvalid_in = 0; dda_tdata_in = '0; dda_tlast_in = 0; new_frame_in = 0;
      pix_valid_in = 0; hcount_in = '0; vcount_in = '0;
      model_reset();
      #1;
      check_all_zero("reset_initial");
      repeat (2) @(posedge clk);
      #2 rst_n_in = 1'b1;
      idle();
      look(0, 0);
      look(319, 239);
      repeat (3) idle();

      // Frame A: in order, lineHeight 100, column 10 oversize, column 11 empty.
      for (int c = 0; c < SW; c++) begin
         lh = (c == 10) ? 255 : (c == 11) ? 0 : 100;
         beat(mk_rec(c, lh, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 65535)),
              c == SW - 1, 0);
      end
      repeat (2) idle();
      cyc(0, '0, 0, 1, 1, 5, 100);
      for (int v = 60; v <= 180; v++) look(5, v);
      for (int v = 0; v <= 245; v++) look(10, v);
      for (int v = 0; v < 240; v += 7) look(11, v);
      for (int i = 0; i < 20; i++) look($urandom_range(320, 511), $urandom_range(0, 255));

      // Frame B: shuffled full frame, completed but held until the next pulse.
      for (int i = 0; i < SW; i++) perm[i] = i;
      for (int i = SW - 1; i > 0; i--) begin
         j = $urandom_range(0, i); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int i = 0; i < SW; i++) begin
         if ($urandom_range(0, 7) == 0) rand_look();
         beat(rand_rec(perm[i]), i == SW - 1, 0);
      end
      for (int i = 0; i < 8; i++) beat(rand_rec($urandom_range(0, SW - 1)), 1, 0);
      for (int i = 0; i < 40; i++) rand_look();
      cyc(0, '0, 0, 1, 1, 7, 120);
      for (int i = 0; i < 150; i++) rand_look();
      cyc(0, '0, 0, 1, 0, 0, 0);
      idle();
      cyc(0, '0, 0, 1, 0, 0, 0);
      idle();

      // Frame C: partial with duplicates and out-of-range beats; tlast coincides with new_frame.
      for (int i = 0; i < 100; i++) begin
         if (i == 30)          beat(rand_rec(400), 0, 0);
         else if (i % 25 == 7) beat(rand_rec($urandom_range(SW, 511)), 0, 0);
         else                  beat(rand_rec($urandom_range(0, SW - 1)), 0, 0);
      end
      beat(rand_rec($urandom_range(0, SW - 1)), 1, 1);
      for (int i = 0; i < 60; i++) rand_look();
      cyc(0, '0, 0, 1, 1, 3, 110);
      for (int i = 0; i < 200; i++) rand_look();

      // Frame D abandoned by an asynchronous reset between clock edges.
      for (int i = 0; i < 50; i++) beat(rand_rec($urandom_range(0, SW - 1)), 0, 0);
      #3 rst_n_in = 1'b0;
      #1;
      check_all_zero("reset_midstream");
      exp_q.delete();
      model_reset();
      @(posedge clk);
      #2 rst_n_in = 1'b1;
      idle();
      for (int i = 0; i < 40; i++) rand_look();

      // Stale counter saturation.
      for (int i = 0; i < 260; i++) cyc(0, '0, 0, 1, 0, 0, 0);
      repeat (4) idle();

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL lookup_drain got %0d results still outstanding want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
